// File: rtl/msg_scatter.sv
// msg_scatter: splits one ZC-bit codeword frame into INNUM lane streams of
// DEPTH rows and emits one beat per cycle of INNUM signed +/-MAG LLRs.
// Optional feature macro: MSG_SCATTER_ERASE_EN adds an erase_mask input. An
// erased (mask bit 1) position emits an LLR of 0.
module msg_scatter #(
    parameter int unsigned INNUM  = 32,
    parameter int unsigned VWIDTH = 6,
    parameter int unsigned DEPTH  = 128,
    parameter int unsigned ADDR_W = 7,
    localparam int unsigned ZC    = INNUM * DEPTH,
    localparam int unsigned DW    = INNUM * VWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ZC-1:0]     in_bits,
`ifdef MSG_SCATTER_ERASE_EN
    input  logic [ZC-1:0]     erase_mask,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              done
);

    localparam logic [VWIDTH-1:0] LLR_POS  = VWIDTH'((1 << (VWIDTH - 1)) - 1);
    localparam logic [VWIDTH-1:0] LLR_NEG  = ~LLR_POS + VWIDTH'(1);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [INNUM-1:0][DEPTH-1:0]   lane_q, lane_d;
    logic [ADDR_W-1:0]             row_q, row_d;
    logic [DW-1:0]                 data_d;
    logic                          last_d;
`ifdef MSG_SCATTER_ERASE_EN
    logic [INNUM-1:0][DEPTH-1:0]   mask_q, mask_d;
`endif

    // Next state, lane shift registers, row counter and next output beat
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        row_d   = row_q;
        data_d  = '0;
        last_d  = 1'b0;
`ifdef MSG_SCATTER_ERASE_EN
        mask_d  = mask_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    for (int k = 0; k < INNUM; k++) begin
                        lane_d[k] = in_bits[k*DEPTH +: DEPTH];
`ifdef MSG_SCATTER_ERASE_EN
                        mask_d[k] = erase_mask[k*DEPTH +: DEPTH];
`endif
                    end
                    row_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (out_ready) begin
                    for (int k = 0; k < INNUM; k++) begin
                        lane_d[k] = lane_q[k] >> 1;
`ifdef MSG_SCATTER_ERASE_EN
                        mask_d[k] = mask_q[k] >> 1;
`endif
                    end
                    // Counter parks on the last row instead of wrapping
                    if (row_q == LAST_ROW) begin
                        state_d = S_DONE;
                    end else begin
                        row_d = row_q + ADDR_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Beat presented next cycle is derived from the post-edge lane LSBs
        if (state_d == S_RUN) begin
            last_d = (row_d == LAST_ROW);
            for (int k = 0; k < INNUM; k++) begin
                data_d[k*VWIDTH +: VWIDTH] = lane_d[k][0] ? LLR_NEG : LLR_POS;
`ifdef MSG_SCATTER_ERASE_EN
                if (mask_d[k][0]) begin
                    data_d[k*VWIDTH +: VWIDTH] = '0;
                end
`endif
            end
        end
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            lane_q    <= '0;
            row_q     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
`ifdef MSG_SCATTER_ERASE_EN
            mask_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            lane_q    <= lane_d;
            row_q     <= row_d;
            in_ready  <= (state_d == S_IDLE);
            out_valid <= (state_d == S_RUN);
            out_data  <= data_d;
            out_addr  <= row_d;
            out_last  <= last_d;
            done      <= (state_d == S_DONE);
`ifdef MSG_SCATTER_ERASE_EN
            mask_q    <= mask_d;
`endif
        end
    end

endmodule

// File: doc/msg_scatter.md
Name: msg_scatter

Overview:
- Splits one Zc-bit hard-decision/codeword frame into INNUM per-lane bit streams of DEPTH bits each.
- Emits one beat per cycle: INNUM signed VWIDTH-bit LLRs plus a row address. Lane k at beat a carries frame bit k*DEPTH + a.
- Used to preload APP RAM rows from a known codeword (warm start, BIST, loopback against the final-message collector). It is the transmit-side counterpart of the lane-gather path.

Parameters:
- INNUM, 32, number of parallel lanes
- VWIDTH, 6, LLR width per lane (two's complement)
- DEPTH, 128, beats per frame (APP RAM rows)
- ADDR_W, 7, row address width; must satisfy 2^ADDR_W >= DEPTH
- ZC, INNUM*DEPTH (4096), frame width in bits
- MAG, 2^(VWIDTH-1)-1 (31), LLR magnitude emitted per bit

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  frame offered on in_bits
- in_ready  out  1  block idle; frame accepted when in_valid & in_ready
- in_bits  in  ZC  frame; bit k*DEPTH+a goes to lane k, row a
- out_valid  out  1  beat valid
- out_ready  in  1  downstream accepts beat
- out_data  out  INNUM*VWIDTH  lane k in [(k+1)*VWIDTH-1 : k*VWIDTH]
- out_addr  out  ADDR_W  row index of current beat
- out_last  out  1  current beat is row DEPTH-1
- done  out  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE, in_ready=1, out_valid=0, out_data=0, out_addr=0, out_last=0, done=0, all lane shift registers 0.
- State IDLE:
  - in_ready=1.
  - On in_valid & in_ready, each lane register k loads in_bits[k*DEPTH +: DEPTH], the row counter clears to 0, and the state moves to RUN.
  - in_ready=0 from the next cycle.
- State RUN:
  - out_valid=1 starting the cycle after accept (latency 1).
  - out_addr = row counter; out_last = (row counter == DEPTH-1).
  - Lane k LLR = +MAG (6'h1F) if the LSB of lane register k is 0, else -MAG (6'h21).
- Beat handshake in RUN:
  - On out_valid & out_ready, every lane register shifts right by 1 and the row counter increments.
  - When out_ready=0, out_data, out_addr and out_last hold stable; no shift occurs.
- End of frame:
  - The beat with out_last=1 being accepted moves the state to DONE.
  - DONE lasts one cycle: done=1, out_valid=0, in_ready=0. It then returns to IDLE.
- Throughput: with out_ready held high, a frame takes exactly DEPTH beat cycles, plus 1 accept cycle and 1 DONE cycle. Minimum accept-to-accept spacing is DEPTH+2 cycles.
- Counter width: the row counter is ADDR_W bits and never wraps inside a frame; it clears on accept.
- in_valid while not IDLE: ignored. in_bits need not be held after accept.
- rst mid-frame: the frame is aborted on the next edge, all outputs return to reset values, and no done pulse is produced.
- All outputs are driven from flops or from a mapping of flops only; no combinational path from in_* or out_ready to out_*. in_ready depends on state only.

Optional Feature:
- Macro: MSG_SCATTER_ERASE_EN
- Defined:
  - Adds input port erase_mask [ZC-1:0], sampled with in_bits at accept into parallel per-lane shift registers.
  - A lane whose current mask LSB is 1 emits LLR 0 (punctured/erased) regardless of its bit.
  - Mask registers shift together with the data registers.
- Undefined: no port and no mask registers; every lane emits ±MAG.

Test Plan:
- Reset: assert rst for 3 cycles mid-RUN at beat 40 -> next cycle out_valid=0, out_data=0, in_ready=1, done=0; a new frame is then accepted normally.
- All-zero frame, out_ready=1 -> 128 beats, out_addr 0..127, every lane 6'h1F, out_last only at addr 127, done pulse one cycle later, in_ready=1 the cycle after.
- Single-one frame, in_bits[5*128+3]=1 -> only beat addr 3 has lane 5 = 6'h21; every other lane/beat is 6'h1F.
- Stall: out_ready=0 for 5 cycles while out_addr=10 -> out_addr, out_data and out_last held; the beat sequence resumes at 10 with no skipped or duplicated rows.
- Back-to-back: in_valid held high with two distinct random frames -> second accept occurs exactly 130 cycles after the first; both streams match the lane-k/row-a mapping bit-exactly; in_valid during RUN is ignored.
- With MSG_SCATTER_ERASE_EN: erase_mask all ones in lane 0 and in_bits all ones -> lane 0 = 0 on all beats, other lanes 6'h21.
